counter_access_arbiter: RTL

- Owns a WIDTH-bit up/down/load counter register and shares it between two requesters.
  - Requester 0: mouse-side logic. Requester 1: housekeeping/reset logic.
- Each requester issues one command at a time over a four-phase req/ack handshake.
- A round-robin FSM serialises the commands.
- Replaces ad-hoc muxing of inc/dec/load paths in front of the counter register.

---
 rtl/counter_access_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/counter_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_access_arbiter
// Brief    : Round-robin arbiter serialising inc/dec/load/clear commands from
//            two four-phase req/ack requesters onto one shared counter.
// Revision : 1.0 - initial release
// ============================================================================
module counter_access_arbiter #(
    parameter int WIDTH = 16,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             req_0,
    input  logic [1:0]       op_0,
    input  logic [WIDTH-1:0] data_0,
    output logic             ack_0,
    input  logic             req_1,
    input  logic [1:0]       op_1,
    input  logic [WIDTH-1:0] data_1,
    output logic             ack_1,
    output logic [WIDTH-1:0] counter,
    output logic             busy,
    output logic             carry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [1:0]       c_op_inc   = 2'b00;
    localparam logic [1:0]       c_op_dec   = 2'b01;
    localparam logic [1:0]       c_op_load  = 2'b10;
    localparam logic [WIDTH-1:0] c_cnt_max  = '1;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               gnt_q, gnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic [1:0]         ack_q, ack_d;
    logic               carry_q, carry_d;

    logic               w_new_gnt;
    logic               w_gnt_req;
    logic [WIDTH-1:0]   w_result;
    logic               w_ovf;

    // Contention resolves by the pointer; otherwise the lone active requester wins.
    assign w_new_gnt = (req_0 & req_1) ? ptr_q : req_1;
    assign w_gnt_req = gnt_q ? req_1 : req_0;

    always_comb begin
        w_result = counter_q;
        w_ovf    = 1'b0;
        case (op_q)
            c_op_inc: begin
                if (counter_q == c_cnt_max) begin
                    w_ovf    = 1'b1;
                    w_result = WRAP ? '0 : counter_q;
                end else begin
                    w_result = counter_q + WIDTH'(1);
                end
            end
            c_op_dec: begin
                if (counter_q == '0) begin
                    w_ovf    = 1'b1;
                    w_result = WRAP ? c_cnt_max : counter_q;
                end else begin
                    w_result = counter_q - WIDTH'(1);
                end
            end
            c_op_load: w_result = data_q;
            default:   w_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        op_d      = op_q;
        data_d    = data_q;
        counter_d = counter_q;
        ack_d     = ack_q;
        carry_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_0 | req_1) begin
                    gnt_d   = w_new_gnt;
                    op_d    = w_new_gnt ? op_1 : op_0;
                    data_d  = w_new_gnt ? data_1 : data_0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                counter_d = w_result;
                carry_d   = w_ovf;
                ack_d     = gnt_q ? 2'b10 : 2'b01;
                state_d   = S_ACK;
            end
            S_ACK: begin
                // Pointer flips only on completion, so a lone requester is never blocked.
                if (!w_gnt_req) begin
                    ack_d   = 2'b00;
                    ptr_d   = ~gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ack_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            op_q      <= 2'b00;
            data_q    <= '0;
            counter_q <= '0;
            ack_q     <= 2'b00;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            op_q      <= op_d;
            data_q    <= data_d;
            counter_q <= counter_d;
            ack_q     <= ack_d;
            carry_q   <= carry_d;
        end
    end

    assign ack_0   = ack_q[0];
    assign ack_1   = ack_q[1];
    assign counter = counter_q;
    assign busy    = (state_q != S_IDLE);
    assign carry   = carry_q;

endmodule
`default_nettype wire
